// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Each bit is held for CLKS_PER_BIT clocks. All outputs are registered from next-state values.
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              txStart,
  input  logic [DATA_W-1:0] TXData,
  output logic              txOut,
  output logic              CTS,
  output logic              txDone
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              r_state, w_state_nxt;
  logic [BW-1:0]       r_baud, w_baud_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_par, w_par_nxt;
  logic                r_tx, r_cts, r_done;
  logic                w_tx_nxt, w_done_nxt, w_bit_end;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_cts   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_cts   <= (w_state_nxt == S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_bit_end   = (r_baud == BAUD_MAX);
    w_baud_nxt  = (r_state == S_IDLE || w_bit_end) ? '0 : r_baud + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (txStart && r_cts) begin
          w_shift_nxt = TXData;
          w_par_nxt   = (^TXData) ^ PAR_ODD;
          w_state_nxt = S_START;
        end
      end
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA: if (w_bit_end) begin
        w_shift_nxt = r_shift >> 1;
        if (r_idx == DATA_LAST) begin
          w_idx_nxt   = '0;
          w_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP: if (w_bit_end) begin
        if (r_idx == STOP_LAST) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Line level for the cycle that follows this edge, so txOut is a plain flop.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
    w_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_MAX) &&
                 (w_idx_nxt == STOP_LAST);
  end

  assign txOut  = r_tx;
  assign CTS    = r_cts;
  assign txDone = r_done;
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one parallel word per handshake into an asynchronous frame: start bit, LSB-first data, optional parity, then one or two stop bits. It has an internal baud-rate divider, so each bit is held for a programmable number of clock cycles rather than one. It replaces the fixed 8N1, one-bit-per-clock transmitter on the UART transmit path and keeps the same txStart/CTS handshake towards the host logic.

## Interface
- DATA_W, 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16: clock cycles per serial bit; minimum 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: selects odd parity when 1 and even parity when 0; ignored if PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- txStart  in  1  transmit request; accepted only in a cycle where CTS=1.
- TXData  in  DATA_W  word to send; sampled only on acceptance.
- txOut  out  1  serial line, registered; idles high.
- CTS  out  1  clear-to-send; high when idle and able to accept txStart.
- txDone  out  1  one-cycle pulse marking the end of a frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (RST_N=0) forces the following immediately, without waiting for a clock edge:
  - state=IDLE, txOut=1, CTS=1, txDone=0.
  - Baud counter, bit index and shift register are cleared.
  - A frame in progress is abandoned; the line returns to idle-high.
- IDLE: txOut=1, CTS=1. When txStart=1 and CTS=1:
  - TXData is latched into the shift register.
  - Parity is computed from the latched data.
  - State moves to START and CTS=0 from the next cycle.
- START: txOut=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: txOut follows the shift register LSB. After each CLKS_PER_BIT cycles the register shifts right and the bit index increments. After DATA_W bits the state moves to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: txOut is held for CLKS_PER_BIT cycles.
  - Even parity is the XOR of all data bits.
  - Odd parity is the inverse of that XOR.
- STOP: txOut=1 for STOP_BITS*CLKS_PER_BIT cycles. txDone=1 during the final cycle of the last stop bit, then the state returns to IDLE.
- txStart while CTS=0 is ignored and is never queued. TXData changes while busy do not affect the frame in progress.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary; no other wrap point is legal.
- Bit index: width $clog2(DATA_W+1).

## Timing
- Acceptance edge N, where txStart=1 and CTS=1. From edge N+1:
  - txOut=0 (start bit begins).
  - CTS=0.
- Frame length F = CLKS_PER_BIT*(1 + DATA_W + PARITY_EN + STOP_BITS) cycles.
- txOut stays at each bit value for exactly CLKS_PER_BIT cycles.
- txDone is high for the single cycle N+F. CTS returns to 1 at N+F+1.
- Back-to-back frames: with txStart held high, the next acceptance is at N+F+1 and the next start bit at N+F+2. This gives exactly one extra idle-high cycle between frames.
- Reset asserted mid-frame: txOut=1 and CTS=1 with no clock edge required. After release, the first valid acceptance is the first rising edge with txStart=1.
- No combinational path from any input to any output.

## Test plan
- 8N1, CLKS_PER_BIT=4, send 0xA5:
  - txOut bits are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total.
  - txDone pulses at cycle 40; CTS rises at cycle 41.
- DATA_W=8, PARITY_EN=1, even parity, send 0x07:
  - Parity bit = 1; frame is 11 bits.
  - Repeat with PARITY_ODD=1: parity bit = 0.
- STOP_BITS=2, DATA_W=7, send 0x7F:
  - Seven 1 data bits, then high for 2*CLKS_PER_BIT cycles.
  - txDone only in the final cycle of the second stop bit.
- Pulse txStart with TXData=0x3C mid-frame while CTS=0:
  - The frame in progress is unchanged and no second frame is sent.
  - Line stays idle after txDone.
- Assert RST_N=0 during the DATA state of 0x00:
  - txOut=1 and CTS=1 immediately, before any clock edge.
  - After release and a new txStart with 0x55, a clean full frame is sent.
- Hold txStart=1 with 0x81 then 0x18:
  - Two complete frames.
  - Exactly one idle-high cycle between the last stop bit of the first frame and the next start bit.
